// File: rtl/mem_stage_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Misses and stores become two back-to-back 16-bit SRAM accesses (low half first).
module mem_stage_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic [3:0]  sram_opcode,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_write_data,
  input  logic [15:0] sram_read_data,
  input  logic        sram_ready
);
  localparam int TAG_W = 17 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t            state;
  logic [16:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       fill;
  logic              was_read;
  logic              prev_ready;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [31:0]       data [LINES];

  logic [INDEX_BITS-1:0] idx, idx_q;
  logic [TAG_W-1:0]      tag, tag_q;
  logic                  hit, hit_q, load, store, done;
  logic                  unused_addr;

  assign idx   = addr[INDEX_BITS+1:2];
  assign tag   = addr[18:INDEX_BITS+2];
  assign idx_q = addr_q[INDEX_BITS-1:0];
  assign tag_q = addr_q[16:INDEX_BITS];
  assign hit   = valid[idx] && (tags[idx] == tag);
  assign hit_q = valid[idx_q] && (tags[idx_q] == tag_q);
  assign store = mem_w_en;
  assign load  = mem_r_en && !mem_w_en;
  // Controller drops ready in the last cycle of each access.
  assign done  = prev_ready && !sram_ready;
  assign unused_addr = ^{addr[31:19], addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_ready <= 1'b0;
      valid      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill       <= '0;
      was_read   <= 1'b0;
    end else begin
      prev_ready <= sram_ready;
      case (state)
        IDLE: begin
          if (store) begin
            addr_q   <= addr[18:2];
            wdata_q  <= wdata;
            was_read <= 1'b0;
            state    <= WR_LO;
          end else if (load && !hit) begin
            addr_q   <= addr[18:2];
            was_read <= 1'b1;
            state    <= RD_LO;
          end
        end
        RD_LO: if (done) begin
          fill[15:0] <= sram_read_data;
          state      <= RD_HI;
        end
        RD_HI: if (done) begin
          fill[31:16]  <= sram_read_data;
          valid[idx_q] <= 1'b1;
          state        <= DONE;
        end
        WR_LO: if (done) state <= WR_HI;
        WR_HI: if (done) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone decide residency.
  always_ff @(posedge clk) begin
    if (!rst && done) begin
      if (state == RD_HI) begin
        tags[idx_q] <= tag_q;
        data[idx_q] <= {sram_read_data, fill[15:0]};
      end else if (state == WR_HI && hit_q) begin
        data[idx_q] <= wdata_q;
      end
    end
  end

  always_comb begin
    rdata           = '0;
    freeze          = 1'b0;
    sram_opcode     = 4'd0;
    sram_addr       = '0;
    sram_write_data = '0;
    case (state)
      IDLE: begin
        if (load && hit) rdata = data[idx];
        freeze = store || (load && !hit);
      end
      RD_LO: begin
        freeze      = 1'b1;
        sram_opcode = 4'd10;
        sram_addr   = {addr_q, 1'b0};
      end
      RD_HI: begin
        freeze      = 1'b1;
        sram_opcode = 4'd10;
        sram_addr   = {addr_q, 1'b1};
      end
      WR_LO: begin
        freeze          = 1'b1;
        sram_opcode     = 4'd11;
        sram_addr       = {addr_q, 1'b0};
        sram_write_data = wdata_q[15:0];
      end
      WR_HI: begin
        freeze          = 1'b1;
        sram_opcode     = 4'd11;
        sram_addr       = {addr_q, 1'b1};
        sram_write_data = wdata_q[31:16];
      end
      DONE: rdata = was_read ? fill : 32'd0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_stage_cache.sv
// Bench for mem_stage_cache: 5-cycle SRAM controller model plus a scoreboard of
// expected SRAM accesses checked as each access completes.
module tb_mem_stage_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        freeze;
  logic [3:0]  sram_opcode;
  logic [17:0] sram_addr;
  logic [15:0] sram_write_data, sram_read_data;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [17:0] a;
    logic [15:0] d;
  } acc_t;
  acc_t sb[$];

  logic [15:0] smem [0:(1<<18)-1];
  logic [3:0]  cnt;

  mem_stage_cache dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .freeze(freeze),
    .sram_opcode(sram_opcode), .sram_addr(sram_addr),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
    .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  // Controller: an access lasts 5 cycles, ready high for 4 then low in the last.
  assign sram_ready     = (sram_opcode != 4'd0) && (cnt < 4'd4);
  assign sram_read_data = smem[sram_addr];

  always @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (sram_opcode != 4'd0) begin
      if (cnt == 4'd4) begin
        cnt <= '0;
        if (sram_opcode == 4'd11) smem[sram_addr] <= sram_write_data;
      end else cnt <= cnt + 4'd1;
    end else cnt <= '0;
  end

  always @(negedge clk) begin
    if (!rst && sram_opcode != 4'd0 && cnt == 4'd4) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sram_access unexpected op=%0d addr=%h", sram_opcode, sram_addr);
      end else begin
        acc_t e;
        e = sb.pop_front();
        if (sram_opcode !== e.op || sram_addr !== e.a ||
            (e.op == 4'd11 && sram_write_data !== e.d)) begin
          errors++;
          $display("FAIL sram_access got op=%0d addr=%h wd=%h want op=%0d addr=%h wd=%h",
                   sram_opcode, sram_addr, sram_write_data, e.op, e.a, e.d);
        end
      end
    end
  end

  task automatic do_access(input string nm, input logic st, input logic both,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic miss, input logic [31:0] exp);
    logic [17:0] lo;
    int n;
    lo = {a[18:2], 1'b0};
    @(negedge clk);
    mem_r_en = !st || both;
    mem_w_en = st;
    addr     = a;
    wdata    = d;
    if (st) begin
      sb.push_back({4'd11, lo, d[15:0]});
      sb.push_back({4'd11, lo | 18'd1, d[31:16]});
    end else if (miss) begin
      sb.push_back({4'd10, lo, 16'd0});
      sb.push_back({4'd10, lo | 18'd1, 16'd0});
    end
    #1;
    if (!st && !miss) begin
      checks++;
      if (freeze !== 1'b0 || rdata !== exp || sram_opcode !== 4'd0) begin
        errors++;
        $display("FAIL %s hit got freeze=%b rdata=%h op=%0d want 0/%h/0", nm, freeze, rdata, sram_opcode, exp);
      end
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      @(negedge clk);
      checks++;
      if (freeze !== 1'b0 || sram_opcode !== 4'd0) begin
        errors++;
        $display("FAIL %s after_hit got freeze=%b op=%0d want 0/0", nm, freeze, sram_opcode);
      end
    end else begin
      checks++;
      if (freeze !== 1'b1) begin
        errors++;
        $display("FAIL %s req_freeze got %b want 1", nm, freeze);
      end
      @(posedge clk); #1;
      // Drop the request and scramble inputs: the latched copy must complete.
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      addr = 32'hFFFF_FFFC; wdata = $urandom;
      n = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!freeze) break;
        n++;
      end
      checks++;
      if (n != 10) begin
        errors++;
        $display("FAIL %s freeze_len got %0d want 10", nm, n);
      end
      checks++;
      if (rdata !== (st ? 32'd0 : exp) || sram_opcode !== 4'd0) begin
        errors++;
        $display("FAIL %s done got rdata=%h op=%0d want %h/0", nm, rdata, sram_opcode, st ? 32'd0 : exp);
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL %s sram_count got %0d pending want 0", nm, sb.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (freeze !== 1'b0 || sram_opcode !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctl got freeze=%b op=%0d want 0/0", freeze, sram_opcode);
    end
    checks++;
    if (sram_addr !== 18'd0 || sram_write_data !== 16'd0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h rdata=%h want 0/0/0", sram_addr, sram_write_data, rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_miss();
    smem[18'h8] = 16'hBEEF;
    smem[18'h9] = 16'hDEAD;
    do_access("load_miss", 1'b0, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF);
  endtask

  task automatic test_load_hit();
    do_access("load_hit", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_store_hit();
    do_access("store_hit", 1'b1, 1'b0, 32'h10, 32'h12345678, 1'b0, 32'd0);
    do_access("store_hit_rd", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'h12345678);
  endtask

  task automatic test_store_miss();
    // Both enables high: must behave as a store.
    do_access("store_miss", 1'b1, 1'b1, 32'h100, 32'hA5A55A5A, 1'b0, 32'd0);
    do_access("store_miss_rd", 1'b0, 1'b0, 32'h100, 32'd0, 1'b1, 32'hA5A55A5A);
  endtask

  task automatic test_conflict();
    smem[18'h88] = 16'hCAFE;
    smem[18'h89] = 16'hF00D;
    do_access("conflict_a", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'h12345678);
    do_access("conflict_b", 1'b0, 1'b0, 32'h110, 32'd0, 1'b1, 32'hF00DCAFE);
    do_access("conflict_b_hit", 1'b0, 1'b0, 32'h110, 32'd0, 1'b0, 32'hF00DCAFE);
    do_access("conflict_a2", 1'b0, 1'b0, 32'h10, 32'd0, 1'b1, 32'h12345678);
  endtask

  task automatic test_reset_mid_fill();
    smem[18'h100] = 16'h1111;
    smem[18'h101] = 16'h2222;
    @(negedge clk);
    mem_r_en = 1'b1;
    addr = 32'h200;
    sb.push_back({4'd10, 18'h100, 16'd0});
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (sram_opcode !== 4'd10 || sram_addr !== 18'h101) begin
      errors++;
      $display("FAIL rst_mid rd_hi got op=%0d addr=%h want 10/00101", sram_opcode, sram_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sram_opcode !== 4'd0 || freeze !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid after got op=%0d freeze=%b rdata=%h want 0/0/0", sram_opcode, freeze, rdata);
    end
    rst = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rst_mid lo_half got %0d pending want 0", sb.size());
    end
    sb.delete();
    do_access("rst_mid_reload", 1'b0, 1'b0, 32'h200, 32'd0, 1'b1, 32'h22221111);
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage_cache.md
Name: mem_stage_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache in the MEM pipeline stage, directly upstream of the SRAM controller.
- Accepts 32-bit load/store requests from the pipeline.
- Serves read hits in zero stall cycles.
- Splits every miss fill and every store into two sequential 16-bit SRAM controller accesses, low half first, and freezes the pipeline meanwhile.

Parameters:
INDEX_BITS  6  log2 of line count (64 one-word lines); tag width = 17-INDEX_BITS

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_r_en  in  1  load request from MEM stage
mem_w_en  in  1  store request from MEM stage
addr  in  32  byte address, word-aligned; bits [18:2] used
wdata  in  32  store data
rdata  out  32  load data to WB stage
freeze  out  1  stall entire pipeline while high
sram_opcode  out  4  to SRAM controller: 10 = read, 11 = write, 0 = idle
sram_addr  out  18  halfword address to SRAM controller
sram_write_data  out  16  halfword to SRAM controller
sram_read_data  in  16  halfword from SRAM controller
sram_ready  in  1  controller busy flag; high during access, low in its final cycle

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[18:INDEX_BITS+2].
- Halfword addresses: lo = {addr[18:2],0}, hi = {addr[18:2],1}.
- Storage: valid[2^INDEX_BITS], tag array, 32-bit data array.
- Reset: all valid bits cleared, state = IDLE, prev_ready = 0.
  - Outputs after reset: freeze = 0, sram_opcode = 0, sram_addr = 0, sram_write_data = 0, rdata = 0.
- Request latch: addr and wdata are latched when leaving IDLE; all later states use the latched copies.
- Both mem_r_en and mem_w_en high: treated as a store.
- Completion strobe: done = prev_ready & ~sram_ready. prev_ready is sram_ready registered every cycle.
- sram_opcode, sram_addr and sram_write_data are combinational from state and latched request.
- Back-to-back halves keep the opcode asserted continuously. The controller restarts from its idle state without a gap.

FSM:
- IDLE
  - freeze = 0, sram_opcode = 0.
  - Load hit (valid & tag match): rdata = data[index] combinationally; stay in IDLE.
  - Load miss: freeze = 1 combinationally, go to RD_LO.
  - Any store: freeze = 1 combinationally, go to WR_LO.
  - No request: rdata = 0.
- RD_LO
  - opcode 10, addr lo, freeze 1.
  - On done: capture sram_read_data into fill[15:0], go to RD_HI.
- RD_HI
  - opcode 10, addr hi, freeze 1.
  - On done: capture fill[31:16]; write data/tag/valid at the latched index; go to DONE.
- WR_LO
  - opcode 11, addr lo, sram_write_data = wdata[15:0], freeze 1.
  - On done: go to WR_HI.
- WR_HI
  - opcode 11, addr hi, sram_write_data = wdata[31:16], freeze 1.
  - On done: if the line hit (valid & tag match), update data[index]; miss leaves the cache unchanged. Go to DONE.
- DONE
  - opcode 0, freeze 0 for one cycle.
  - rdata = fill register after a read, 0 after a write.
  - Pipeline advances on this edge; return to IDLE.

Timing (controller takes 5 cycles per access):
- Load miss and store: freeze high 10 cycles, DONE on the 11th.
- Load hit: 0 stall.

Boundary conditions:
- Conflict miss: the fill overwrites the resident line unconditionally (write-through, never dirty).
- Reset mid-fill: line not validated; state goes to IDLE next cycle; opcode 0; controller is reset by the same rst.
- Request deasserted while frozen: ignored; the latched request completes.

Test Plan:
1. After reset, load addr 0x00000010 with SRAM model halfwords 0x0008 = 0xBEEF, 0x0009 = 0xDEAD:
   - freeze high 10 cycles, opcode 10 at 0x00008 then 0x00009.
   - DONE: rdata = 0xDEADBEEF, freeze = 0.
2. Repeat load of 0x10 → freeze stays 0, rdata = 0xDEADBEEF same cycle, sram_opcode stays 0.
3. Store 0x12345678 to 0x10 (hit):
   - opcode 11 at 0x00008 with data 0x5678, then 0x00009 with 0x1234; 10-cycle freeze.
   - Next load of 0x10 hits, rdata = 0x12345678.
4. Store to 0x100 (miss) → two SRAM writes, cache unchanged; next load of 0x100 misses (10-cycle freeze).
5. Load 0x10, then load 0x110 (same index 4, different tag) → second load misses and evicts; load 0x10 misses again.
6. Assert rst during RD_HI of a load miss:
   - opcode 0 and freeze 0 next cycle.
   - Subsequent load of the same address misses (valid not set).
